// File: rtl/dispatch_stage_pkg.sv
// Shared types and constants for the tensor-core dispatch stage.
// The entry record keeps the decoded fields needed for hazard checks and issue.
package dispatch_stage_pkg;
  localparam int WORD_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_W    = 5;
  localparam int NUM_FU   = 5;
  localparam int FU_W     = 3;

  typedef enum logic [FU_W-1:0] {
    FU_ALU    = 3'd0,
    FU_SLDST  = 3'd1,
    FU_BRANCH = 3'd2,
    FU_MLDST  = 3'd3,
    FU_GEMM   = 3'd4
  } fu_idx_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } disp_state_t;

  // fu_index stays a raw field: values 5..7 must be representable to be dropped
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic              rs1_used;
    logic              rs2_used;
    logic [REG_W-1:0]  rd;
    logic              wen;
    logic [FU_W-1:0]   fu_index;
  } dispatch_t;

  function automatic logic fu_legal(input logic [FU_W-1:0] idx);
    return idx < FU_W'(NUM_FU);
  endfunction
endpackage

// File: rtl/dispatch_stage_scoreboard.sv
// Pending-write scoreboard over the scalar register file; reg 0 never pends.
// Lookups read registered bits only, so a writeback unblocks a reader one cycle later.
module dispatch_stage_scoreboard
  import dispatch_stage_pkg::*;
#(
  parameter int NUM_REGS = dispatch_stage_pkg::NUM_REGS,
  parameter int REG_W    = dispatch_stage_pkg::REG_W,
  parameter int NUM_LK   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         set_en,
  input  logic [REG_W-1:0]             set_idx,
  input  logic                         clr_en,
  input  logic [REG_W-1:0]             clr_idx,
  input  logic [NUM_LK-1:0][REG_W-1:0] lk_idx,
  output logic [NUM_LK-1:0]            lk_hit,
  output logic [NUM_REGS-1:0]          pending
);
  // Later non-blocking writes win: set overrides clear, reg 0 is forced low last.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (clr_en) pending[clr_idx] <= 1'b0;
      if (set_en) pending[set_idx] <= 1'b1;
      pending[0] <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_LK; k++) begin : g_lk
    assign lk_hit[k] = pending[lk_idx[k]];
  end
endmodule

// File: rtl/dispatch_stage.sv
// Single-entry dispatch stage: holds one decoded instruction, checks RAW/WAW
// against the scoreboard and FU busy, and issues it with its FU index.
module dispatch_stage #(
  parameter int WORD_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int NUM_FU   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  logic [WORD_W-1:0]   dec_instr,
  input  logic [REG_W-1:0]    dec_rs1,
  input  logic [REG_W-1:0]    dec_rs2,
  input  logic                dec_rs1_used,
  input  logic                dec_rs2_used,
  input  logic [REG_W-1:0]    dec_rd,
  input  logic                dec_wen,
  input  logic [2:0]          dec_fu_index,
  output logic                disp_valid,
  input  logic                disp_ready,
  output logic [WORD_W-1:0]   disp_instr,
  output logic [2:0]          disp_fu_index,
  output logic [REG_W-1:0]    disp_rd,
  output logic                disp_wen,
  input  logic [NUM_FU-1:0]   fu_busy,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_rd,
  input  logic                flush,
  output logic                err_illegal_fu,
  output logic [NUM_REGS-1:0] sb_pending
);
  import dispatch_stage_pkg::dispatch_t;
  import dispatch_stage_pkg::disp_state_t;
  import dispatch_stage_pkg::ST_EMPTY;
  import dispatch_stage_pkg::ST_HELD;
  import dispatch_stage_pkg::fu_legal;

  disp_state_t state_q, state_d;
  dispatch_t   entry_q, entry_d;

  logic            entry_valid, hazard, fu_blocked, fu_ok, drop_illegal;
  logic            dec_fire, disp_fire;
  logic [2:0]      lk_hit;
  logic [2:0][REG_W-1:0] lk_idx;
  logic [7:0]      busy_ext;

  assign entry_valid = (state_q == ST_HELD);

  assign lk_idx = {entry_q.rd, entry_q.rs2, entry_q.rs1};

  dispatch_stage_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W),
    .NUM_LK   (3)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (disp_fire & entry_q.wen & (entry_q.rd != '0)),
    .set_idx (entry_q.rd),
    .clr_en  (wb_valid & (wb_rd != '0)),
    .clr_idx (wb_rd),
    .lk_idx  (lk_idx),
    .lk_hit  (lk_hit),
    .pending (sb_pending)
  );

  assign hazard = (entry_q.rs1_used & lk_hit[0]) |
                  (entry_q.rs2_used & lk_hit[1]) |
                  (entry_q.wen      & lk_hit[2]);

  // Widen busy to the full 3-bit index space so illegal indices read a zero.
  assign busy_ext     = {{(8-NUM_FU){1'b0}}, fu_busy};
  assign fu_blocked   = busy_ext[entry_q.fu_index];
  assign fu_ok        = fu_legal(entry_q.fu_index);
  assign drop_illegal = entry_valid & !fu_ok;

  assign disp_valid = !rst & entry_valid & !hazard & !fu_blocked & !flush & fu_ok;
  assign disp_fire  = disp_valid & disp_ready;
  assign dec_ready  = rst | !entry_valid | disp_fire | flush | drop_illegal;
  assign dec_fire   = dec_valid & dec_ready;

  assign err_illegal_fu = !rst & drop_illegal;

  assign disp_instr    = rst ? '0 : entry_q.instr;
  assign disp_fu_index = rst ? '0 : entry_q.fu_index;
  assign disp_rd       = rst ? '0 : entry_q.rd;
  assign disp_wen      = !rst & entry_q.wen;

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    case (state_q)
      ST_EMPTY: if (dec_fire) state_d = ST_HELD;
      ST_HELD: begin
        if (dec_fire)                                 state_d = ST_HELD;
        else if (disp_fire | flush | drop_illegal)    state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (dec_fire) begin
      entry_d.instr    = dec_instr;
      entry_d.rs1      = dec_rs1;
      entry_d.rs2      = dec_rs2;
      entry_d.rs1_used = dec_rs1_used;
      entry_d.rs2_used = dec_rs2_used;
      entry_d.rd       = dec_rd;
      entry_d.wen      = dec_wen;
      entry_d.fu_index = dec_fu_index;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
    end
  end
endmodule
